master_ctrl: RTL and testbench

MASTER_CTRL -- requirements
Module: master_ctrl

---
 rtl/master_pkg.sv | 23 ++
 rtl/master_qtick.sv | 47 ++++
 rtl/master_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_master_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/master_pkg.sv
// rtl/master_pkg.sv - shared state encodings and quarter-phase constants for the I2C master
package master_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_ADDR      = 4'd2,
        ST_ADDR_ACK  = 4'd3,
        ST_WRITE     = 4'd4,
        ST_WRITE_ACK = 4'd5,
        ST_READ      = 4'd6,
        ST_READ_ACK  = 4'd7,
        ST_STOP      = 4'd8
    } master_state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [2:0] LAST_BIT = 3'd7;

endpackage

// File: rtl/master_qtick.sv
// rtl/master_qtick.sv - quarter-period tick generator; MASTER_CLK_STRETCH_EN enables q2 freeze on low SCL
module master_qtick
    import master_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       scl_in,
    output logic       tick,
    output logic [1:0] q
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div;
    logic       hold;

`ifdef MASTER_CLK_STRETCH_EN
    // a slave holding SCL low during our high phase stretches the bit
    assign hold = (q == Q2) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold          = 1'b0;
`endif

    assign tick = run && !hold && (div == DIV_LAST);

    // divider and quarter counter, parked at zero whenever the master is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            q   <= Q0;
        end else if (!run) begin
            div <= '0;
            q   <= Q0;
        end else if (tick) begin
            div <= '0;
            q   <= q + 2'd1;
        end else if (!hold) begin
            div <= div + 8'd1;
        end
    end

endmodule

// File: rtl/master_ctrl.sv
// rtl/master_ctrl.sv - single-byte I2C master sequencer; MASTER_CLK_STRETCH_EN enables slave clock stretching
module master_ctrl
    import master_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       fpga_clk,
    input  logic       master_reset,
    input  logic       master_req,
    input  logic [6:0] master_addr,
    input  logic       master_rd_wr,
    input  logic [7:0] master_wdata,
    output logic       master_busy,
    output logic       master_done,
    output logic       master_nack,
    output logic [7:0] master_rdata,
    output logic       master_scl,
    output logic       master_sda_out,
    output logic       master_tri_en,
    input  logic       master_sda_in,
    input  logic       master_scl_in
);

    master_state_t state, state_n;

    logic       tick;
    logic [1:0] q;
    logic       accept;
    logic       bit_end;
    logic [2:0] bit_cnt;
    logic [6:0] addr_q;
    logic       rd_wr_q;
    logic [7:0] wdata_q;
    logic [7:0] addr_byte;
    logic [7:0] rx_shift;
    logic       nack_flag;
    logic       tx_bit;
    logic       sda_q;
    logic       tri_q;

    assign accept      = (state == ST_IDLE) && master_req;
    assign bit_end     = tick && (q == Q3);
    assign master_busy = (state != ST_IDLE);
    assign addr_byte   = {addr_q, rd_wr_q};
    // bits go out MSB first, so bit_cnt 0 selects bit 7
    assign tx_bit      = (state == ST_ADDR) ? addr_byte[~bit_cnt] : wdata_q[~bit_cnt];

    assign master_sda_out = sda_q;
    assign master_tri_en  = tri_q;

    master_qtick #(
        .CLK_DIV (CLK_DIV)
    ) u_qtick (
        .clk    (fpga_clk),
        .rst_n  (master_reset),
        .run    (master_busy),
        .scl_in (master_scl_in),
        .tick   (tick),
        .q      (q)
    );

    // state register
    always_ff @(posedge fpga_clk or negedge master_reset) begin
        if (!master_reset) state <= ST_IDLE;
        else               state <= state_n;
    end

    // next state: every move after START happens at the end of a bit period
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:      if (master_req) state_n = ST_START;
            ST_START:     if (bit_end) state_n = ST_ADDR;
            ST_ADDR:      if (bit_end && bit_cnt == LAST_BIT) state_n = ST_ADDR_ACK;
            ST_ADDR_ACK:  if (bit_end) state_n = master_sda_in ? ST_STOP : (rd_wr_q ? ST_READ : ST_WRITE);
            ST_WRITE:     if (bit_end && bit_cnt == LAST_BIT) state_n = ST_WRITE_ACK;
            ST_WRITE_ACK: if (bit_end) state_n = ST_STOP;
            ST_READ:      if (bit_end && bit_cnt == LAST_BIT) state_n = ST_READ_ACK;
            ST_READ_ACK:  if (bit_end) state_n = ST_STOP;
            ST_STOP:      if (bit_end) state_n = ST_IDLE;
            default:      state_n = ST_IDLE;
        endcase
    end

    // SCL follows the quarter phase; idle and START keep it high, STOP lifts it after q0
    always_comb begin
        master_scl = 1'b1;
        case (state)
            ST_IDLE, ST_START: master_scl = 1'b1;
            ST_STOP:           master_scl = (q != Q0);
            default:           master_scl = (q == Q2) || (q == Q3);
        endcase
    end

    // SDA drive and release: each value takes effect on the tick that enters its quarter
    always_ff @(posedge fpga_clk or negedge master_reset) begin
        if (!master_reset) begin
            sda_q <= 1'b1;
            tri_q <= 1'b1;
        end else if (accept) begin
            sda_q <= 1'b1;
            tri_q <= 1'b0;
        end else if (tick) begin
            case (q)
                Q3: begin
                    if (state_n == ST_STOP) begin
                        sda_q <= 1'b0;
                        tri_q <= 1'b0;
                    end else if (state_n == ST_IDLE) begin
                        sda_q <= 1'b1;
                        tri_q <= 1'b1;
                    end
                end
                Q0: begin
                    case (state)
                        ST_ADDR, ST_WRITE: begin
                            sda_q <= tx_bit;
                            tri_q <= 1'b0;
                        end
                        ST_ADDR_ACK, ST_WRITE_ACK, ST_READ: begin
                            sda_q <= 1'b1;
                            tri_q <= 1'b1;
                        end
                        ST_READ_ACK: begin
                            sda_q <= 1'b1;
                            tri_q <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                Q1: begin
                    if (state == ST_START)     sda_q <= 1'b0;
                    else if (state == ST_STOP) sda_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // request capture, bit counting, read shifting and result registers
    always_ff @(posedge fpga_clk or negedge master_reset) begin
        if (!master_reset) begin
            addr_q       <= '0;
            rd_wr_q      <= 1'b0;
            wdata_q      <= '0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            nack_flag    <= 1'b0;
            master_done  <= 1'b0;
            master_nack  <= 1'b0;
            master_rdata <= 8'h00;
        end else begin
            master_done <= 1'b0;
            if (accept) begin
                addr_q    <= master_addr;
                rd_wr_q   <= master_rd_wr;
                wdata_q   <= master_wdata;
                bit_cnt   <= '0;
                nack_flag <= 1'b0;
            end
            if (bit_end) begin
                case (state)
                    ST_ADDR, ST_WRITE: bit_cnt <= bit_cnt + 3'd1;
                    ST_READ: begin
                        bit_cnt  <= bit_cnt + 3'd1;
                        rx_shift <= {rx_shift[6:0], master_sda_in};
                    end
                    ST_ADDR_ACK, ST_WRITE_ACK: if (master_sda_in) nack_flag <= 1'b1;
                    ST_STOP: begin
                        master_done <= 1'b1;
                        master_nack <= nack_flag;
                        // only a read whose address was acknowledged produced data
                        if (rd_wr_q && !nack_flag) master_rdata <= rx_shift;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_master_ctrl.sv
// tb/tb_master_ctrl.sv - scoreboard bench for master_ctrl with a behavioural I2C slave
module tb_master_ctrl;

    localparam int CLK_DIV = 4;
    localparam int BIT_CYC = 4 * CLK_DIV;
`ifdef MASTER_CLK_STRETCH_EN
    localparam int STRETCH_EXTRA = 10;
`else
    localparam int STRETCH_EXTRA = 0;
`endif

    logic       fpga_clk     = 1'b0;
    logic       master_reset = 1'b0;
    logic       master_req   = 1'b0;
    logic [6:0] master_addr  = '0;
    logic       master_rd_wr = 1'b0;
    logic [7:0] master_wdata = '0;
    logic       master_busy;
    logic       master_done;
    logic       master_nack;
    logic [7:0] master_rdata;
    logic       master_scl;
    logic       master_sda_out;
    logic       master_tri_en;
    logic       master_sda_in;
    logic       master_scl_in = 1'b1;

    logic slave_drive = 1'b1;

    // open-drain line: master and slave wired-AND
    assign master_sda_in = (master_tri_en ? 1'b1 : master_sda_out) & slave_drive;

    master_ctrl #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .fpga_clk       (fpga_clk),
        .master_reset   (master_reset),
        .master_req     (master_req),
        .master_addr    (master_addr),
        .master_rd_wr   (master_rd_wr),
        .master_wdata   (master_wdata),
        .master_busy    (master_busy),
        .master_done    (master_done),
        .master_nack    (master_nack),
        .master_rdata   (master_rdata),
        .master_scl     (master_scl),
        .master_sda_out (master_sda_out),
        .master_tri_en  (master_tri_en),
        .master_sda_in  (master_sda_in),
        .master_scl_in  (master_scl_in)
    );

    always #5 fpga_clk = ~fpga_clk;

    typedef struct {
        int unsigned accept_cyc;
        int unsigned lat;
        logic        nack;
        logic [7:0]  rdata;
        logic [7:0]  byte0;
        logic [7:0]  byte1;
        logic        has_data;
        logic        is_read;
        int unsigned nrise;
    } exp_t;

    exp_t sb_q[$];

    int n_vec    = 0;
    int n_miscmp = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    int unsigned cyc = 0;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    logic        prev_scl  = 1'b1;
    logic        prev_line = 1'b1;
    logic        prev_done = 1'b0;
    logic        bits [0:31];
    int unsigned nrise     = 0;
    logic        stop_seen = 1'b0;
    logic        rdack_ok  = 1'b0;
    int unsigned done_cnt  = 0;

    logic       cur_ack_addr = 1'b1;
    logic       cur_ack_data = 1'b1;
    logic       cur_read     = 1'b0;
    logic [7:0] cur_rbyte    = '0;
    logic [7:0] exp_rdata    = 8'h00;
    logic       opt_busy_req = 1'b0;
    logic       opt_stretch  = 1'b0;

    // bus monitor, slave responder and scoreboard checker, sampled mid-cycle
    always @(negedge fpga_clk) begin
        exp_t       e;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       line;
        line = (master_tri_en ? 1'b1 : master_sda_out) & slave_drive;
        if (prev_scl && master_scl && prev_line && !line) begin
            nrise     = 0;
            stop_seen = 1'b0;
            rdack_ok  = 1'b0;
        end
        if (prev_scl && master_scl && !prev_line && line) stop_seen = 1'b1;
        if (!prev_scl && master_scl) begin
            if (nrise < 32) bits[nrise] = line;
            if (nrise == 17) rdack_ok = !master_tri_en && master_sda_out;
            nrise++;
        end
        if (prev_scl && !master_scl) begin
            slave_drive = 1'b1;
            if (nrise == 8) slave_drive = !cur_ack_addr;
            else if (cur_ack_addr && cur_read && nrise >= 9 && nrise <= 16) slave_drive = cur_rbyte[3'(16 - nrise)];
            else if (cur_ack_addr && !cur_read && nrise == 17) slave_drive = !cur_ack_data;
        end
        if (prev_done) chk_eq("done_width", master_done, 1'b0);
        if (master_done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk_eq("spurious_done", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                for (int i = 0; i < 8; i++) begin
                    b0[7-i] = bits[i];
                    b1[7-i] = bits[9+i];
                end
                chk_eq("latency", cyc - e.accept_cyc, e.lat);
                chk_eq("nack", master_nack, e.nack);
                chk_eq("rdata", master_rdata, e.rdata);
                chk_eq("addr_byte", b0, e.byte0);
                if (e.has_data) chk_eq("data_byte", b1, e.byte1);
                chk_eq("scl_rises", nrise, e.nrise);
                chk_eq("stop_seen", stop_seen, 1'b1);
                if (e.is_read && e.has_data) chk_eq("read_master_nack", rdack_ok, 1'b1);
            end
        end
        prev_done = master_done;
        prev_scl  = master_scl;
        prev_line = (master_tri_en ? 1'b1 : master_sda_out) & slave_drive;
    end

    task automatic run_txn(input logic [6:0] addr, input logic rw, input logic [7:0] wdata,
                           input logic ack_a, input logic ack_d, input logic [7:0] rbyte);
        exp_t        e;
        int unsigned d0;
        logic        nk;
        @(negedge fpga_clk);
        cur_ack_addr = ack_a;
        cur_ack_data = ack_d;
        cur_read     = rw;
        cur_rbyte    = rbyte;
        chk_eq("busy_idle", master_busy, 1'b0);
        master_req   = 1'b1;
        master_addr  = addr;
        master_rd_wr = rw;
        master_wdata = wdata;
        nk = !ack_a || (!rw && !ack_d);
        if (rw && ack_a) exp_rdata = rbyte;
        e.accept_cyc = cyc + 1;
        e.lat        = (ack_a ? 20 : 11) * BIT_CYC + (opt_stretch ? STRETCH_EXTRA : 0);
        e.nack       = nk;
        e.rdata      = exp_rdata;
        e.byte0      = {addr, rw};
        e.byte1      = rw ? rbyte : wdata;
        e.has_data   = ack_a;
        e.is_read    = rw;
        e.nrise      = ack_a ? 19 : 10;
        sb_q.push_back(e);
        d0 = done_cnt;
        @(negedge fpga_clk);
        master_req   = 1'b0;
        master_addr  = ~addr;
        master_rd_wr = ~rw;
        master_wdata = ~wdata;
        chk_eq("busy_after_accept", master_busy, 1'b1);
        if (opt_stretch) begin
            repeat (8) @(negedge fpga_clk);
            master_scl_in = 1'b0;
            repeat (10) @(negedge fpga_clk);
            master_scl_in = 1'b1;
        end
        if (opt_busy_req) begin
            repeat (200) @(negedge fpga_clk);
            chk_eq("busy_mid_write", master_busy, 1'b1);
            master_req   = 1'b1;
            master_wdata = 8'hFF;
            @(negedge fpga_clk);
            master_req   = 1'b0;
        end
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge fpga_clk);
        chk_eq("done_seen", done_cnt - d0, 1);
        repeat (4) @(negedge fpga_clk);
        chk_eq("busy_after_done", master_busy, 1'b0);
        chk_eq("done_count", done_cnt - d0, 1);
        chk_eq("nack_hold", master_nack, nk);
        chk_eq("rdata_hold", master_rdata, exp_rdata);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_eq({tag, "_scl"}, master_scl, 1'b1);
        chk_eq({tag, "_sda"}, master_sda_out, 1'b1);
        chk_eq({tag, "_tri"}, master_tri_en, 1'b1);
        chk_eq({tag, "_busy"}, master_busy, 1'b0);
        chk_eq({tag, "_done"}, master_done, 1'b0);
        chk_eq({tag, "_nack"}, master_nack, 1'b0);
        chk_eq({tag, "_rdata"}, master_rdata, 8'h00);
    endtask

    task automatic reset_mid_addr();
        int unsigned d0;
        @(negedge fpga_clk);
        cur_ack_addr = 1'b1;
        cur_ack_data = 1'b1;
        cur_read     = 1'b0;
        master_req   = 1'b1;
        master_addr  = 7'h33;
        master_rd_wr = 1'b0;
        master_wdata = 8'h44;
        d0 = done_cnt;
        @(negedge fpga_clk);
        master_req = 1'b0;
        repeat (60) @(posedge fpga_clk);
        #2 master_reset = 1'b0;
        #1 check_reset_outputs("rst_mid");
        exp_rdata = 8'h00;
        repeat (3) @(negedge fpga_clk);
        master_reset = 1'b1;
        repeat (30) @(negedge fpga_clk);
        chk_eq("no_done_after_reset", done_cnt - d0, 0);
    endtask

    initial begin
        master_reset = 1'b0;
        repeat (3) @(negedge fpga_clk);
        check_reset_outputs("por");
        master_reset = 1'b1;
        repeat (2) @(negedge fpga_clk);

        run_txn(7'b1111010, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
        run_txn(7'b1111010, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C);
        run_txn(7'b1111010, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h00);
        opt_busy_req = 1'b1;
        run_txn(7'b1111010, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
        opt_busy_req = 1'b0;
        run_txn(7'h21, 1'b0, 8'h96, 1'b1, 1'b0, 8'h00);
        run_txn(7'h55, 1'b1, 8'h00, 1'b0, 1'b1, 8'hC3);
        opt_stretch = 1'b1;
        run_txn(7'h12, 1'b0, 8'h81, 1'b1, 1'b1, 8'h00);
        opt_stretch = 1'b0;
        reset_mid_addr();
        sb_q.delete();
        run_txn(7'h6B, 1'b1, 8'h00, 1'b1, 1'b1, 8'hE7);
        run_txn(7'h01, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
